// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// A single 2*XLEN accumulator is shared by shift-add multiply and
// restoring divide. Operands are reduced to magnitudes on issue, and the
// sign is restored on the last iteration. Divide-by-zero and signed
// overflow skip the iteration and complete in one cycle.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; operands are captured on start
// CALC   | one shift-add / restoring-divide step per cycle
// DONE   | result valid, done pulse; returns to IDLE
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        func3_q, func3_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, fast;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, step, prod_fix;
  logic [XLEN-1:0]   quo, rem, fix_res;

  // Issue-time decode: signedness, magnitudes and fast-path detection
  always_comb begin
    is_div   = func3[2];
    a_sgn    = is_div ? ~func3[0] : (func3[1:0] != 2'b11);
    b_sgn    = is_div ? ~func3[0] : ~func3[1];
    a_neg    = a_sgn & op_a[XLEN-1];
    b_neg    = b_sgn & op_b[XLEN-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    div_zero = (op_b == '0);
    div_ovf  = ~func3[0] & (op_a == MOST_NEG) & (op_b == '1);
    fast     = is_div & (div_zero | div_ovf);
    if (div_zero) fast_res = func3[1] ? op_a : '1;
    else          fast_res = func3[1] ? '0 : op_a;
  end

  // One iteration of the shared datapath plus the final sign fix-up
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = rem_sh - {1'b0, opnd_q};
    // a negative trial difference means the divisor did not fit: restore
    if (div_diff[XLEN]) div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else                div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step     = func3_q[2] ? div_next : mul_next;
    prod_fix = neg_q ? -step : step;
    quo      = step[XLEN-1:0];
    rem      = step[2*XLEN-1:XLEN];
    if (func3_q[2]) begin
      if (func3_q[1]) fix_res = neg_q ? -rem : rem;
      else            fix_res = neg_q ? -quo : quo;
    end else begin
      fix_res = (func3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  // FSM next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    func3_d  = func3_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          func3_d = func3;
          cnt_d   = '0;
          neg_d   = (is_div && func3[1]) ? a_neg : (a_neg ^ b_neg);
          if (is_div) begin
            opnd_d = b_mag;
            acc_d  = {{XLEN{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{XLEN{1'b0}}, b_mag};
          end
          if (fast) begin
            result_d = fast_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          result_d = fix_res;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset that aborts any op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      func3_q  <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      func3_q  <= func3_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  // Status outputs; stall drops in DONE so the core retires that cycle
  always_comb begin
    busy   = (state_q == S_CALC) || (state_q == S_DONE);
    done   = (state_q == S_DONE);
    stall  = ((state_q == S_IDLE) && start) || (state_q == S_CALC);
    result = result_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed and random ops, scoreboard-checked
// against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, stall;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .result(result), .stall(stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] exp;
    int          lat;
    int          scyc;
    logic [2:0]  f;
  } exp_t;

  exp_t        scb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_exp = '0;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sbv, ua, ub, p;
    int ia, ib;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sbv; return p[31:0];  end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding op
  always @(negedge clk) begin
    if (done) begin
      n_vec++;
      if (scb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: result %h with nothing outstanding (cycle %0d)", result, cyc);
      end else begin
        mon_e = scb.pop_front();
        if (result !== mon_e.exp || (cyc - mon_e.scyc) != mon_e.lat) begin
          n_err++;
          $display("FAIL op_f%0d: got %h latency %0d, required %h latency %0d",
                   mon_e.f, result, cyc - mon_e.scyc, mon_e.exp, mon_e.lat);
        end
      end
    end
  end

  task automatic push_exp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.exp  = ref_model(f, a, b);
    e.lat  = ref_lat(f, a, b);
    e.scyc = cyc;
    e.f    = f;
    last_exp = e.exp;
    scb.push_back(e);
  endtask

  // Drives start for exactly one cycle; returns just after the edge that drops it
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    func3 = f; op_a = a; op_b = b; start = 1'b1;
    push_exp(f, a, b);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_idle: busy still %b after 200 cycles, required 0", busy);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = $urandom_range(0, 20);
      4:       v = -$urandom_range(1, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  logic [2:0]  dir_f[12] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd0};
  logic [31:0] dir_a[12] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                             32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                             32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
  logic [31:0] dir_b[12] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h0000_0000};

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_stall", stall, 0);

    // MUL 7 x -3 with cycle-accurate stall/done/busy checks
    @(posedge clk); #1;
    func3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFF_FFFD; start = 1'b1;
    push_exp(3'd0, 32'd7, 32'hFFFF_FFFD);
    c = cyc;
    @(negedge clk);
    chk("stall_c0", stall, 1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      chk("calc_stall", stall, 1);
      chk("calc_busy", busy, 1);
      chk("calc_done", done, 0);
    end
    @(negedge clk);
    chk("c33_cycle", cyc - c, 33);
    chk("c33_done", done, 1);
    chk("c33_stall", stall, 0);
    chk("c33_result", result, 32'hFFFF_FFEB);
    @(negedge clk);
    chk("c34_busy", busy, 0);

    // Directed table from the arithmetic corner cases
    for (int i = 0; i < 12; i++) begin
      issue(dir_f[i], dir_a[i], dir_b[i]);
      wait_idle();
    end
    repeat (3) @(negedge clk);
    chk("result_hold", result, last_exp);

    // start re-asserted mid-CALC with different operands is ignored
    issue(3'd4, 32'd1000, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    func3 = 3'd0; op_a = 32'hDEAD_BEEF; op_b = 32'h0000_0003; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    chk("ignored_start_drain", scb.size(), 0);

    // reset in cycle 10 of CALC aborts the op
    issue(3'd1, 32'h7654_3210, 32'h0BAD_CAFE);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(scb.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_stall", stall, 0);
    issue(3'd5, 32'd100, 32'd7);
    wait_idle();

    // rst and start together: rst wins
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; func3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", busy, 0);

    // random ops
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      wait_idle();
    end

    repeat (40) @(negedge clk);
    chk("scoreboard_empty", scb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
